clk_sel_ctrl: RTL

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_pkg.sv | 17 +
 rtl/settle_cnt.sv | 28 ++
 rtl/clk_sel_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/clk_sel_pkg.sv
// rtl/clk_sel_pkg.sv - shared select codes, FSM state type and settle defaults for clk_sel_ctrl
package clk_sel_pkg;

    localparam logic [1:0] CLK_SEL_1   = 2'b00;
    localparam logic [1:0] CLK_SEL_2   = 2'b01;
    localparam logic [1:0] CLK_SEL_3   = 2'b10;
    localparam logic [1:0] CLK_SEL_BAD = 2'b11;

    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int SETTLE_CNT_W      = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } sel_state_t;

endpackage

// File: rtl/settle_cnt.sv
// rtl/settle_cnt.sv - loadable down-counter with zero flag timing the settle window
module settle_cnt #(
    parameter int W = 8
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - clock-select request controller with settle window; CLK_SEL_CTRL_ERR_EN enables the sticky err flag
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic [1:0] sel_clk1,
    output logic       busy,
    output logic       switch_done,
    output logic       err,
    input  logic       err_clr
);

    // The change edge is settle cycle 1, so the counter starts one below the window length.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    sel_state_t r_state;
    sel_state_t w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic       w_accept;
    logic       w_load;
    logic       w_dec;
    logic       w_cnt_zero;
    logic       w_err_set;
    logic       w_switch_done;

    assign req_ready = rst_n && (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    settle_cnt #(
        .W (SETTLE_CNT_W)
    ) u_settle_cnt (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state decode: IDLE takes requests, SETTLE counts down and ends with a done pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        w_err_set     = 1'b0;
        w_switch_done = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                if (req_sel == CLK_SEL_BAD) begin
                    w_err_set = 1'b1;
                end else if (req_sel != r_sel) begin
                    w_sel_nxt   = req_sel;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
        end else begin
            if (w_cnt_zero) begin
                w_state_nxt   = ST_IDLE;
                w_switch_done = 1'b1;
            end else begin
                w_dec = 1'b1;
            end
        end
    end

    // State and select register; reset drops any window in flight and returns to clk1.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= CLK_SEL_1;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    assign sel_clk1    = r_sel;
    assign busy        = (r_state == ST_SETTLE);
    assign switch_done = w_switch_done;

`ifdef CLK_SEL_CTRL_ERR_EN
    logic r_err;

    // Sticky error: a new invalid request beats a simultaneous clear.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_err;

    assign w_unused_err = err_clr | w_err_set;
    assign err          = 1'b0;
`endif

endmodule
